// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Two-master Wishbone B4 classic arbiter and address decoder.
//            It grants the shared slave bus round-robin, holds the grant
//            while the owner's cyc stays high, and strobes one of three
//            slaves (flash, RAM, control) by address window. It routes the
//            responses and read data back to the owner only, and answers
//            unmapped accesses with a one-cycle err.
// Ports    : clk_i, rst_i (synchronous, active low)
//            m0_* / m1_*  : master ports (cyc, stb, we, adr, dat, sel in;
//                           dat, ack, err, rty out)
//            s_*_o        : shared slave request (stb is one bit per slave)
//            s_dat_i      : {ctrl, ram, flash} read data
//            s_ack_i/s_err_i/s_rty_i : per-slave responses
// Options  : WB_ARBITER_TIMEOUT_EN - when defined, a strobe that waits
//            TIMEOUT cycles for a response is abandoned with a bus error.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
  parameter logic [31:0] FLASH_SIZE = 32'h0020_0000,
  parameter logic [31:0] RAM_BASE   = 32'h2000_0000,
  parameter logic [31:0] RAM_SIZE   = 32'h0001_0000,
  parameter logic [31:0] CTRL_BASE  = 32'h3000_0000,
  parameter logic [31:0] CTRL_SIZE  = 32'h0000_0100,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_stb_o,
  input  logic [95:0] s_dat_i,
  input  logic [2:0]  s_ack_i,
  input  logic [2:0]  s_err_i,
  input  logic [2:0]  s_rty_i
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("wb_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state;
  logic   last;       // master granted most recently (1 = m1)
  logic   err_owner;  // owner to return to after ERR

  // Ownership covers the ERR cycle too, so the error reaches the right master.
  logic own0, own1, owned, strobing_state;
  assign own0           = (state == OWN0) || ((state == ERR) && !err_owner);
  assign own1           = (state == OWN1) || ((state == ERR) && err_owner);
  assign owned          = own0 || own1;
  assign strobing_state = (state == OWN0) || (state == OWN1);

  logic cur_cyc, cur_stb, oth_cyc;
  assign cur_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = own1 ? m1_stb_i : m0_stb_i;
  assign oth_cyc = own1 ? m0_cyc_i : m1_cyc_i;

  assign s_cyc_o = owned && cur_cyc;
  assign s_we_o  = owned && (own1 ? m1_we_i : m0_we_i);
  assign s_adr_o = owned ? (own1 ? m1_adr_i : m0_adr_i) : 32'd0;
  assign s_dat_o = owned ? (own1 ? m1_dat_i : m0_dat_i) : 32'd0;
  assign s_sel_o = owned ? (own1 ? m1_sel_i : m0_sel_i) : 4'd0;

  // Window test as an unsigned offset compare; wraps below base so one
  // comparison covers both base <= adr and adr < base + size.
  logic [2:0] hit;
  assign hit[0] = (s_adr_o - FLASH_BASE) < FLASH_SIZE;
  assign hit[1] = (s_adr_o - RAM_BASE)   < RAM_SIZE;
  assign hit[2] = (s_adr_o - CTRL_BASE)  < CTRL_SIZE;

  assign s_stb_o = (strobing_state && cur_cyc && cur_stb) ? hit : 3'b000;

  logic ack_any, err_any, rty_any;
  assign ack_any = |(s_ack_i & s_stb_o);
  assign err_any = |(s_err_i & s_stb_o);
  assign rty_any = |(s_rty_i & s_stb_o);

  logic [31:0] rd_dat;
  assign rd_dat = ({32{hit[0]}} & s_dat_i[31:0])
                | ({32{hit[1]}} & s_dat_i[63:32])
                | ({32{hit[2]}} & s_dat_i[95:64]);

  assign m0_ack_o = own0 && ack_any;
  assign m0_rty_o = own0 && rty_any;
  assign m0_err_o = own0 && (err_any || (state == ERR));
  assign m0_dat_o = own0 ? rd_dat : 32'd0;
  assign m1_ack_o = own1 && ack_any;
  assign m1_rty_o = own1 && rty_any;
  assign m1_err_o = own1 && (err_any || (state == ERR));
  assign m1_dat_o = own1 ? rd_dat : 32'd0;

  logic tmo_hit;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt;
  logic       waiting;
  assign waiting = (|s_stb_o) && !(ack_any || err_any || rty_any);
  // Fires on the TIMEOUT-th waiting cycle, so ERR follows on the next edge.
  assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i || !waiting || tmo_hit) begin
      tmo_cnt <= 8'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      err_owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state <= last ? OWN0 : OWN1;
            last  <= !last;
          end else if (m0_cyc_i) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!cur_cyc) begin
            // Direct handover keeps the bus busy without an IDLE cycle.
            if (oth_cyc) begin
              state <= own1 ? OWN0 : OWN1;
              last  <= !own1;
            end else begin
              state <= IDLE;
            end
          end else if ((cur_stb && (hit == 3'b000)) || tmo_hit) begin
            state     <= ERR;
            err_owner <= own1;
          end
        end
        ERR: begin
          state <= err_owner ? OWN1 : OWN0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
